iobuf_bank: RTL and testbench
=============================

IOBUF_BANK -- requirements
Module: iobuf_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of bidirectional pad channels (≥1).
REQ-002 The block SHALL have parameter TURNAROUND, default 2, giving the minimum hi-Z cycles after a drive release before drive may reassert (0..255).
REQ-003 The block SHALL have parameter IN_STAGES, default 2, giving the number of input register stages (≥1).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port out_i, input, WIDTH bits: data to drive onto the pads.
REQ-007 The block SHALL have port oe_req_i, input, 1 bit: request to drive the pads.
REQ-008 The block SHALL have port clr_i, input, 1 bit: clear the contention counter.
REQ-009 The block SHALL have port io, inout, WIDTH bits: the pads.
REQ-010 The block SHALL have port in_o, output, WIDTH bits: the pad value after IN_STAGES registers.
REQ-011 The block SHALL have port oe_o, output, 1 bit: pads actually driven (registered oe_q).
REQ-012 The block SHALL have port guard_o, output, 1 bit: turnaround guard active.
REQ-013 The block SHALL have port cont_cnt_o, output, 8 bits: saturating count of contention cycles.
REQ-014 The block SHALL have port contention_o, output, 1 bit: high when cont_cnt_o != 0.

Function
REQ-015 The block SHALL drive io = out_q when oe_q = 1 and all-Z otherwise, per channel.
REQ-016 The block SHALL register out_i into out_q on every clock edge, giving a latency of 1 cycle from out_i to the pad while driving.
REQ-017 The block SHALL implement an FSM with states IDLE (oe_q=0), DRIVE (oe_q=1) and GUARD (oe_q=0, guard_o=1).
REQ-018 In IDLE with oe_req_i=1, the block SHALL go to DRIVE at the next edge, so oe_o rises 1 cycle after the request.
REQ-019 In DRIVE with oe_req_i=0, the block SHALL deassert oe_q at the next edge, go to GUARD with guard counter = TURNAROUND, or go directly to IDLE when TURNAROUND = 0.
REQ-020 In GUARD, the block SHALL decrement the counter each cycle, ignore oe_req_i, and go to IDLE on the edge where the counter goes 1 -> 0, so the hi-Z gap is exactly TURNAROUND cycles.
REQ-021 If oe_req_i is high when GUARD exits, the block SHALL pass through IDLE and enter DRIVE one cycle later; the total gap SHALL be TURNAROUND+1 cycles.
REQ-022 The block SHALL sample in_o through an IN_STAGES-deep register chain from io, with a latency of IN_STAGES cycles, and SHALL propagate X/Z values unchanged in simulation.
REQ-023 The block SHALL detect contention on any edge where oe_q = 1 and any bit of io differs from out_q (4-state compare: X/Z counts as a mismatch).
REQ-024 On a contention edge, the block SHALL increment cont_cnt_o, saturating at 255.
REQ-025 clr_i SHALL zero cont_cnt_o.
REQ-026 When clr_i and contention occur on the same edge, cont_cnt_o SHALL become 1.
REQ-027 When oe_req_i toggles during GUARD, the block SHALL produce no effect until GUARD exits.
REQ-028 oe_req_i pulses of 1 cycle in IDLE SHALL produce exactly 1 DRIVE cycle followed by GUARD.

Reset
REQ-029 On rst_i=1 at an edge, the block SHALL set state to IDLE, oe_q = 0, out_q = 0, guard counter = 0, cont_cnt_o = 0, and all input stages = 0.
REQ-030 Reset mid-DRIVE or mid-GUARD SHALL release the pads at that edge with no guard period; after reset the block SHALL honour oe_req_i from the first non-reset edge.

Verification
REQ-031 The bench SHALL cover the following scenario, with WIDTH=8, TURNAROUND=2, IN_STAGES=2: oe_req_i=1, out_i=0xA5 from reset release -> oe_o=1 and io=0xA5 after 1 edge, and in_o=0xA5 2 edges later.
REQ-032 The bench SHALL cover the following scenario: drop oe_req_i while in DRIVE and reassert it the next cycle -> io=Z for exactly 3 cycles (2 GUARD + 1 IDLE), with guard_o high for 2 cycles.
REQ-033 The bench SHALL cover the following scenario: with oe_o=1, an external driver forces io[3] opposite for 4 cycles -> cont_cnt_o=4 and contention_o=1; then clr_i for 1 cycle -> 0.
REQ-034 The bench SHALL cover the following scenario: external contention held for 300 cycles -> cont_cnt_o saturates at 255; clr_i asserted on a contention edge -> 1.
REQ-035 The bench SHALL cover the following scenario: rst_i asserted during GUARD and during DRIVE -> oe_o=0, guard_o=0 and cont_cnt_o=0 next edge; an oe_req_i held at reset release gives DRIVE 1 edge later.
REQ-036 The bench SHALL cover the following scenario: TURNAROUND=0 build with oe_req_i toggling every cycle -> oe_o follows oe_req_i delayed by 1 cycle, with guard_o never asserted.

Source files
------------

// File: rtl/iobuf_bank.sv
// iobuf_bank: bank of bidirectional pads with a drive-release turnaround guard,
// registered input sampling and a saturating contention counter.
module iobuf_bank #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned IN_STAGES  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] out_i,
  input  logic             oe_req_i,
  input  logic             clr_i,
  inout  wire  [WIDTH-1:0] io,
  output logic [WIDTH-1:0] in_o,
  output logic             oe_o,
  output logic             guard_o,
  output logic [7:0]       cont_cnt_o,
  output logic             contention_o
);
  localparam int unsigned      CNT_W      = 8;
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(TURNAROUND);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GUARD = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_gcnt;
  logic [CNT_W-1:0] w_gcnt_nxt;
  logic             r_oe;
  logic             r_guard;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_in [IN_STAGES];
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_contention;
  logic             w_cont;

  assign io = r_oe ? r_out : {WIDTH{1'bz}};

  // 4-state compare so a floating or fought-over pad counts as contention
  assign w_cont = r_oe && (io !== r_out);

  // Drive / turnaround sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_gcnt_nxt  = r_gcnt;
    case (r_state)
      IDLE: begin
        if (oe_req_i) w_state_nxt = DRIVE;
      end
      DRIVE: begin
        if (!oe_req_i) begin
          if (TURNAROUND == 0) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = GUARD;
            w_gcnt_nxt  = GUARD_LOAD;
          end
        end
      end
      GUARD: begin
        w_gcnt_nxt = r_gcnt - CNT_W'(1);
        if (r_gcnt <= CNT_W'(1)) begin
          w_state_nxt = IDLE;
          w_gcnt_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gcnt_nxt  = '0;
      end
    endcase
  end

  // Clear wins over accumulation but still records a contention on the same edge
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr_i) begin
      w_cnt_nxt = w_cont ? CNT_W'(1) : '0;
    end else if (w_cont && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_gcnt       <= '0;
      r_oe         <= 1'b0;
      r_guard      <= 1'b0;
      r_out        <= '0;
      r_cnt        <= '0;
      r_contention <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_gcnt       <= w_gcnt_nxt;
      r_oe         <= (w_state_nxt == DRIVE);
      r_guard      <= (w_state_nxt == GUARD);
      r_out        <= out_i;
      r_cnt        <= w_cnt_nxt;
      r_contention <= (w_cnt_nxt != '0);
    end
  end

  // Input sampling chain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(IN_STAGES); i++) r_in[i] <= '0;
    end else begin
      r_in[0] <= io;
      for (int i = 1; i < int'(IN_STAGES); i++) r_in[i] <= r_in[i-1];
    end
  end

  assign in_o         = r_in[IN_STAGES-1];
  assign oe_o         = r_oe;
  assign guard_o      = r_guard;
  assign cont_cnt_o   = r_cnt;
  assign contention_o = r_contention;

endmodule

// File: tb/tb_iobuf_bank.sv
// Bench for iobuf_bank: directed scenarios plus randomized traffic checked
// every cycle against a behavioural pad/guard/counter model.
module tb_iobuf_bank;
  localparam int unsigned W  = 8;
  localparam int unsigned TA = 2;
  localparam int unsigned NS = 2;

  logic         clk = 1'b0;
  logic         rst, oe_req, clr, oe_req2;
  logic [W-1:0] out_v;
  logic [W-1:0] ext_oe, ext_val;
  wire  [W-1:0] io, io2;
  logic [W-1:0] in_o, in2_o;
  logic         oe_o, guard_o, cont_o, oe2_o, guard2_o, cont2_o;
  logic [7:0]   cnt_o, cnt2_o;

  int   n_vec = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  // External per-bit driver fighting or replacing the DUT on the pads
  for (genvar g = 0; g < W; g++) begin : g_ext
    assign io[g] = ext_oe[g] ? ext_val[g] : 1'bz;
  end

  iobuf_bank #(.WIDTH(W), .TURNAROUND(TA), .IN_STAGES(NS)) dut (
    .clk_i(clk), .rst_i(rst), .out_i(out_v), .oe_req_i(oe_req), .clr_i(clr),
    .io(io), .in_o(in_o), .oe_o(oe_o), .guard_o(guard_o),
    .cont_cnt_o(cnt_o), .contention_o(cont_o)
  );

  iobuf_bank #(.WIDTH(W), .TURNAROUND(0), .IN_STAGES(NS)) dut0 (
    .clk_i(clk), .rst_i(rst), .out_i(out_v), .oe_req_i(oe_req2), .clr_i(clr),
    .io(io2), .in_o(in2_o), .oe_o(oe2_o), .guard_o(guard2_o),
    .cont_cnt_o(cnt2_o), .contention_o(cont2_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Pad resolution: {known-bit mask, value}; bits driven by nobody or fought over are unknown
  function automatic logic [2*W-1:0] resolve(input logic oe, input logic [W-1:0] dv,
                                              input logic [W-1:0] eo, input logic [W-1:0] ev);
    logic [W-1:0] v, k;
    if (oe) begin
      v = dv;
      k = ~eo | ~(ev ^ dv);
    end else begin
      v = ev;
      k = eo;
    end
    return {k, v};
  endfunction

  // Behavioural model
  logic         m_oe = 1'b0;
  int           m_gleft = 0;
  logic [W-1:0] m_out = '0;
  int           m_cnt = 0;
  logic [W-1:0] m_pv [NS];
  logic [W-1:0] m_pm [NS];

  always @(posedge clk) begin
    logic [2*W-1:0] r;
    logic           cont;
    r    = resolve(m_oe, m_out, ext_oe, ext_val);
    cont = m_oe && ((ext_oe & (ext_val ^ m_out)) != '0);
    if (rst) begin
      m_oe    <= 1'b0;
      m_gleft <= 0;
      m_out   <= '0;
      m_cnt   <= 0;
      for (int i = 0; i < int'(NS); i++) begin
        m_pv[i] <= '0;
        m_pm[i] <= '1;
      end
    end else begin
      for (int i = 1; i < int'(NS); i++) begin
        m_pv[i] <= m_pv[i-1];
        m_pm[i] <= m_pm[i-1];
      end
      m_pv[0] <= r[W-1:0];
      m_pm[0] <= r[2*W-1:W];
      if (clr) m_cnt <= cont ? 1 : 0;
      else if (cont && m_cnt < 255) m_cnt <= m_cnt + 1;
      m_out <= out_v;
      if (m_gleft > 0) m_gleft <= m_gleft - 1;
      else if (m_oe && !oe_req) begin
        m_oe    <= 1'b0;
        m_gleft <= int'(TA);
      end else if (!m_oe && oe_req) m_oe <= 1'b1;
    end
  end

  // Per-cycle compare against the model
  always @(posedge clk) begin
    logic [2*W-1:0] rr;
    #2;
    if (chk_en) begin
      rr = resolve(m_oe, m_out, ext_oe, ext_val);
      chk("oe_o", 32'(oe_o), 32'(m_oe));
      chk("guard_o", 32'(guard_o), 32'(m_gleft != 0));
      chk("cont_cnt_o", 32'(cnt_o), 32'(m_cnt));
      chk("contention_o", 32'(cont_o), 32'(m_cnt != 0));
      chk("in_o", 32'(in_o & m_pm[NS-1]), 32'(m_pv[NS-1] & m_pm[NS-1]));
      chk("io", 32'(io & rr[2*W-1:W]), 32'(rr[W-1:0] & rr[2*W-1:W]));
    end
  end

  initial begin
    int   zc, gc;
    logic done;
    rst = 1'b1; oe_req = 1'b0; clr = 1'b0; oe_req2 = 1'b0;
    out_v = '0; ext_oe = '0; ext_val = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_oe", 32'(oe_o), 0);
    chk("rst_guard", 32'(guard_o), 0);
    chk("rst_cnt", 32'(cnt_o), 0);
    chk("rst_in", 32'(in_o), 0);

    // Drive 0xA5 straight out of reset
    rst = 1'b0; oe_req = 1'b1; out_v = 8'hA5;
    @(negedge clk);
    chk("a5_oe", 32'(oe_o), 1);
    chk("a5_io", 32'(io), 32'h A5);
    repeat (2) @(negedge clk);
    chk("a5_in", 32'(in_o), 32'h A5);

    // Release and immediately re-request: guard gap
    oe_req = 1'b0;
    @(negedge clk);
    oe_req = 1'b1;
    zc = 0; gc = 0; done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!done) begin
        if (oe_o) done = 1'b1;
        else begin
          zc++;
          if (guard_o) gc++;
          @(negedge clk);
        end
      end
    end
    chk("gap_done", 32'(done), 1);
    chk("gap_z_cycles", 32'(zc), 3);
    chk("gap_guard_cycles", 32'(gc), 2);

    // Four cycles of io[3] forced opposite, then clear
    ext_val = '1; ext_oe = 8'h08;
    repeat (4) @(negedge clk);
    ext_oe = '0;
    chk("cont4_cnt", 32'(cnt_o), 4);
    chk("cont4_flag", 32'(cont_o), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_cnt", 32'(cnt_o), 0);
    chk("clr_flag", 32'(cont_o), 0);

    // Saturation, then clear coinciding with contention
    ext_oe = 8'h08;
    repeat (300) @(negedge clk);
    chk("sat_cnt", 32'(cnt_o), 255);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; ext_oe = '0;
    chk("clr_cont_cnt", 32'(cnt_o), 1);
    chk("clr_cont_flag", 32'(cont_o), 1);

    // Reset during GUARD
    oe_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_guard", 32'(guard_o), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstg_oe", 32'(oe_o), 0);
    chk("rstg_guard", 32'(guard_o), 0);
    chk("rstg_cnt", 32'(cnt_o), 0);
    rst = 1'b0; oe_req = 1'b1;
    @(negedge clk);
    chk("post_rst_drive", 32'(oe_o), 1);

    // Reset during DRIVE
    ext_oe = 8'h08;
    repeat (2) @(negedge clk);
    ext_oe = '0;
    chk("pre_rstd_cnt", 32'(cnt_o), 2);
    rst = 1'b1;
    @(negedge clk);
    chk("rstd_oe", 32'(oe_o), 0);
    chk("rstd_guard", 32'(guard_o), 0);
    chk("rstd_cnt", 32'(cnt_o), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rstd_drive", 32'(oe_o), 1);

    // Zero-turnaround instance follows the request one cycle late
    for (int k = 0; k < 20; k++) begin
      oe_req2 = ~oe_req2;
      @(negedge clk);
      chk("ta0_oe", 32'(oe2_o), 32'(oe_req2));
      chk("ta0_guard", 32'(guard2_o), 0);
    end

    // Randomized traffic; external driver only overpowers low bits while the DUT drives
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(3) == 0) oe_req = ~oe_req;
      out_v = W'($urandom);
      clr   = ($urandom_range(15) == 0);
      rst   = ($urandom_range(199) == 0);
      if (m_oe) begin
        ext_val = '1;
        ext_oe  = ($urandom_range(3) == 0) ? W'($urandom) : '0;
      end else begin
        ext_val = W'($urandom);
        ext_oe  = ($urandom_range(1) == 1) ? '1 : W'($urandom);
      end
      @(negedge clk);
    end

    rst = 1'b0; clr = 1'b0; ext_oe = '0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
